// File: rtl/ssi_encoder_emulator.sv
// ssi_encoder_emulator: SSI slave that plays an absolute encoder, sending header,
// position, err/warn flags and an inverted CRC6 (x^6+x+1) MSB first.
module ssi_encoder_emulator #(
    parameter int          ENCODER_DATA_BITS = 44,
    parameter logic [63:0] HEADER_VALUE      = 64'd0,
    parameter int          TIMEOUT_CYCLES    = 200
) (
    input  logic        clk_100m,
    input  logic        rst_syn,
    input  logic        ssi_c,
    output logic        ssi_d,
    input  logic [31:0] position,
    input  logic        err_bit,
    input  logic        warn_bit,
    input  logic        inject_crc_err,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_abort,
    output logic [7:0]  frame_cnt
);
    localparam int W  = ENCODER_DATA_BITS;
    localparam int CW = $clog2(W + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, TIMEOUT} state_t;

    state_t        state_q;
    logic          ssi_s1_q, ssi_s2_q, ssi_prev_q;
    logic [33:0]   payload_q;
    logic          inject_q;
    logic [5:0]    crc_q, crc_d;
    logic [CW-1:0] bit_cnt_q;
    logic [TW-1:0] high_cnt_q;
    logic [W-1:0]  frame_w, frame_sh;
    logic          fall, rise, full;

    assign fall  = ssi_prev_q & ~ssi_s2_q;
    assign rise  = ~ssi_prev_q & ssi_s2_q;
    assign full  = bit_cnt_q == CW'(W);
    // Header bits sit above the 40-bit payload; truncation keeps only W-40 of them
    assign frame_w  = W'({HEADER_VALUE, payload_q, ~(crc_q ^ {5'b0, inject_q})});
    assign frame_sh = frame_w << bit_cnt_q;

    always_comb begin
        crc_d = '0;
        for (int i = 33; i >= 0; i--)
            crc_d = {crc_d[4:1], crc_d[0] ^ crc_d[5] ^ payload_q[i], crc_d[5] ^ payload_q[i]};
    end

    always_ff @(posedge clk_100m or posedge rst_syn) begin
        if (rst_syn) begin
            ssi_s1_q    <= 1'b1;
            ssi_s2_q    <= 1'b1;
            ssi_prev_q  <= 1'b1;
            state_q     <= IDLE;
            payload_q   <= '0;
            inject_q    <= 1'b0;
            crc_q       <= '0;
            bit_cnt_q   <= '0;
            high_cnt_q  <= '0;
            ssi_d       <= 1'b1;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            ssi_s1_q    <= ssi_c;
            ssi_s2_q    <= ssi_s1_q;
            ssi_prev_q  <= ssi_s2_q;
            crc_q       <= crc_d;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            case (state_q)
                IDLE: begin
                    ssi_d      <= 1'b1;
                    bit_cnt_q  <= '0;
                    high_cnt_q <= '0;
                    if (fall) begin
                        payload_q <= {position, err_bit, warn_bit};
                        inject_q  <= inject_crc_err;
                        busy      <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Once every bit is out the shift has emptied, so overclocking reads 0
                    if (rise) begin
                        ssi_d <= frame_sh[W-1];
                        if (!full)
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                    high_cnt_q <= (fall || !ssi_s2_q) ? '0 : high_cnt_q + 1'b1;
                    if (high_cnt_q == TW'(TIMEOUT_CYCLES)) begin
                        state_q     <= TIMEOUT;
                        frame_done  <= full;
                        frame_abort <= !full;
                        frame_cnt   <= frame_cnt + 8'(full);
                    end
                end
                default: begin
                    ssi_d   <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ssi_encoder_emulator.sv
// tb_ssi_encoder_emulator: SSI master model driving the encoder emulator, with a
// scoreboard of expected frames checked whenever the DUT ends a frame.
module tb_ssi_encoder_emulator;
    localparam int          T   = 60;
    localparam int          W   = 44;
    localparam logic [63:0] HDR = 64'hA;

    logic        clk_100m = 1'b0, rst_syn = 1'b0, ssi_c = 1'b1, ssi_d;
    logic        err_bit = 1'b0, warn_bit = 1'b0, inject_crc_err = 1'b0;
    logic        busy, frame_done, frame_abort;
    logic [31:0] position = '0;
    logic [7:0]  frame_cnt;
    logic [7:0]  cnt_model = '0;
    logic        rx [1:64];
    int          vectors = 0, miscompares = 0, cyc = 0, rise_cyc = 0;

    typedef struct {
        logic        abort;
        logic [7:0]  cnt;
        logic [43:0] frame;
        int          n;
        bit          chk;
    } exp_t;
    exp_t sb[$];

    ssi_encoder_emulator #(
        .ENCODER_DATA_BITS(W),
        .HEADER_VALUE(HDR),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_100m(clk_100m),
        .rst_syn(rst_syn),
        .ssi_c(ssi_c),
        .ssi_d(ssi_d),
        .position(position),
        .err_bit(err_bit),
        .warn_bit(warn_bit),
        .inject_crc_err(inject_crc_err),
        .busy(busy),
        .frame_done(frame_done),
        .frame_abort(frame_abort),
        .frame_cnt(frame_cnt)
    );

    always #5 clk_100m = ~clk_100m;
    always @(posedge clk_100m) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Frame from first principles: CRC is the remainder of payload*x^6 by long division
    function automatic logic [43:0] model_frame(logic [31:0] p, logic e, logic w, logic inj);
        logic [33:0] m;
        logic [39:0] v;
        logic [5:0]  c;
        m = {p, e, w};
        v = {m, 6'b0};
        for (int i = 39; i >= 6; i--)
            if (v[i]) v = v ^ (40'h43 << (i - 6));
        c = v[5:0] ^ {5'b0, inj};
        return {HDR[3:0], m, ~c};
    endfunction

    initial begin
        logic [63:0] got, want;
        exp_t e;
        forever begin
            @(negedge clk_100m);
            if (frame_done || frame_abort) begin
                if (sb.size() == 0) begin
                    check("spurious_pulse", {frame_done, frame_abort}, 0);
                end else begin
                    e = sb.pop_front();
                    check("pulse_kind", {frame_done, frame_abort}, e.abort ? 2'b01 : 2'b10);
                    check("frame_cnt", frame_cnt, e.cnt);
                    check("end_latency", cyc - rise_cyc, T + 3);
                    if (e.chk) begin
                        got = '0;
                        want = '0;
                        for (int k = 1; k <= e.n; k++) begin
                            got[k-1] = rx[k];
                            want[k-1] = (k == 1) ? 1'b1 : (k - 2 < W) ? e.frame[W-1-(k-2)] : 1'b0;
                        end
                        check("rx_bits", got, want);
                    end
                    @(negedge clk_100m);
                    check("back_to_idle", {busy, ssi_d, frame_done, frame_abort}, 4'b0100);
                end
            end
        end
    end

    // One master transaction of n clock pulses; optional mid-frame input change or reset
    task automatic run_frame(input int n, input int half, input bit chk,
                             input int chg_at = 0, input logic [31:0] new_pos = '0,
                             input int rst_at = 0);
        exp_t e;
        e.frame = model_frame(position, err_bit, warn_bit, inject_crc_err);
        e.n     = n;
        e.chk   = chk;
        e.abort = n < W;
        if (rst_at == 0) begin
            if (!e.abort) cnt_model++;
            e.cnt = cnt_model;
            sb.push_back(e);
        end
        @(negedge clk_100m);
        for (int i = 1; i <= n; i++) begin
            if (i == 2) check("busy_in_frame", busy, 1'b1);
            ssi_c = 1'b0;
            rx[i] = ssi_d;
            repeat (half) @(negedge clk_100m);
            ssi_c = 1'b1;
            rise_cyc = cyc;
            if (i == chg_at) position = new_pos;
            repeat (half) @(negedge clk_100m);
            if (i == rst_at) begin
                #3 rst_syn = 1'b1;
                #1 check("async_reset", {ssi_d, busy, frame_cnt}, {1'b1, 1'b0, 8'd0});
                @(negedge clk_100m);
                rst_syn = 1'b0;
                cnt_model = '0;
                break;
            end
        end
        for (int k = 0; k < T + 10 && sb.size() > 0; k++) @(negedge clk_100m);
        if (sb.size() > 0) begin
            check("frame_end_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (3) @(negedge clk_100m);
    endtask

    initial begin
        rst_syn = 1'b1;
        repeat (2) @(negedge clk_100m);
        check("reset_state", {ssi_d, busy, frame_done, frame_abort, frame_cnt}, {4'b1000, 8'd0});
        rst_syn = 1'b0;
        repeat (3) @(negedge clk_100m);

        position = 32'h12345678;
        run_frame(44, 13, 1);
        check("cnt_after_nominal", frame_cnt, 8'd1);

        {err_bit, warn_bit, inject_crc_err} = 3'b111;
        run_frame(44, 13, 1);
        run_frame(44, 13, 1);
        inject_crc_err = 1'b0;
        run_frame(44, 13, 1);

        {err_bit, warn_bit} = 2'b00;
        position = 32'h0000FFFF;
        run_frame(44, 13, 1, 10, 32'hFFFF0000);
        run_frame(44, 13, 1);

        run_frame(20, 13, 1);
        check("cnt_after_abort", frame_cnt, cnt_model);
        run_frame(50, 13, 1);

        for (int r = 0; r < 6; r++) begin
            position       = $urandom;
            err_bit        = 1'($urandom);
            warn_bit       = 1'($urandom);
            inject_crc_err = 1'($urandom);
            run_frame($urandom_range(0, 1) ? int'($urandom_range(44, 50)) : int'($urandom_range(2, 43)),
                      $urandom_range(5, 9), 1);
        end

        {err_bit, warn_bit, inject_crc_err} = 3'b000;
        position = 32'h12340000;
        run_frame(44, 13, 1, 0, '0, 21);
        position = $urandom;
        run_frame(44, 13, 1);

        // Fast back-to-back frames just to walk the counter round; data is not sampled
        for (int r = 0; r < 255; r++) run_frame(44, 2, 0);
        check("cnt_wrapped", frame_cnt, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ssi_encoder_emulator.md
# ssi_encoder_emulator

SSI slave that plays the absolute-encoder side of the motor absolute-encoder link. It answers the SSI clock from the motor controller's SSI master with a 44-bit frame: header, 32-bit position, error/warning bits, and inverted CRC6 (x^6+x+1, 0x43). It sits on the motor board test header and in the top-level loopback build, so the SSI master can be exercised without a physical encoder.

## Interface
- ENCODER_DATA_BITS, 44, frame length; must be ≥ 40; header width = ENCODER_DATA_BITS-40.
- HEADER_VALUE, 0, header bits sent first, MSB first.
- TIMEOUT_CYCLES, 200, clk_100m cycles of continuous ssi_c high that end a frame (monoflop time); must be > 2×SSI period.
- clk_100m  in  1  system clock, 100 MHz.
- rst_syn  in  1  reset, asynchronous, active-high.
- ssi_c  in  1  SSI clock from master; asynchronous; idles high.
- ssi_d  out  1  SSI data to master.
- position  in  32  position value to transmit.
- err_bit  in  1  encoder error flag to transmit.
- warn_bit  in  1  encoder warning flag to transmit.
- inject_crc_err  in  1  level; when high at frame capture, the frame's CRC bit 0 is flipped.
- busy  out  1  high from frame capture until return to IDLE.
- frame_done  out  1  one-cycle pulse when a complete frame ends by timeout.
- frame_abort  out  1  one-cycle pulse when a frame times out with fewer than ENCODER_DATA_BITS bits sent.
- frame_cnt  out  8  completed-frame counter; wraps 255→0.

## Operation
- ssi_c passes through a 2-FF synchronizer and an edge detector: fall = prev 1 / now 0; rise = prev 0 / now 1.
- Frame word, MSB first: [43:40] HEADER_VALUE, [39:8] position, [7] err_bit, [6] warn_bit, [5:0] ~crc.
- crc: Galois LFSR with init 0. Per data bit d: n0=c5^d, n1=c0^c5^d, n2..n5=c1..c4. Runs over frame bits 39..6 (34 bits, MSB first). With inject_crc_err captured high, crc[0] is inverted before transmission.
- Property: when the receiver feeds bits 39..6 plus the complement of received bits 5..0, its remainder is 0.
- States:
  - IDLE: ssi_d=1; bit_cnt=0. On fall, capture position, err_bit, warn_bit, inject_crc_err; go SHIFT; busy=1.
  - SHIFT: on each rise, ssi_d ← frame bit (ENCODER_DATA_BITS-1-bit_cnt) and bit_cnt increments. Once bit_cnt = ENCODER_DATA_BITS, later rises drive ssi_d=0. Falls do not change ssi_d. The high-time counter clears on every fall and on every cycle ssi_c is low. On high-time = TIMEOUT_CYCLES, go TIMEOUT.
  - TIMEOUT: one cycle. If bit_cnt ≥ ENCODER_DATA_BITS, pulse frame_done and increment frame_cnt; otherwise pulse frame_abort. Then ssi_d=1, busy=0, go IDLE.
- Inputs changing during SHIFT do not affect the frame in flight.
- A fall in TIMEOUT is ignored. The next frame needs a fall observed in IDLE.
- bit_cnt saturates at ENCODER_DATA_BITS.

## Timing
- Reset values: ssi_d=1, busy=0, frame_done=0, frame_abort=0, frame_cnt=0, state IDLE, crc=0. A mid-frame reset returns everything to these values asynchronously.
- ssi_c edge to internal detect: 2 cycles (synchronizer). ssi_d update: registered, 3 cycles after the pin edge.
- Capture happens in the detect cycle of the first fall. crc is valid 1 cycle after capture, well before rise #1, since the minimum half-period is ≥ 5 cycles.
- Bit k (k=0 first) appears 3 cycles after rise k+1. The master samples it on fall k+2, so it sees frame bits 43..0 on falls 2..45.
- busy rises 1 cycle after fall detect. frame_done, frame_abort and frame_cnt change TIMEOUT_CYCLES+1 cycles after the last rise detect.
- Supported SSI period: ≥ 10 clk_100m cycles. Master default: 26.

## Test plan
- Nominal: position=0x12345678, err=0, warn=0, master period 26. Master reads abs position 0x12345678, crc_err_cnt stays 0, status bits stay 0. frame_done pulses once; frame_cnt=1.
- Flags and CRC fault: err=1, warn=1, inject_crc_err=1. Master status_bits=2'b11 and crc_err_cnt increments by 1 per frame. Repeat with inject=0: crc_err_cnt does not change.
- Mid-frame change: position switches 0x0000FFFF→0xFFFF0000 after rise #10. Master reads 0x0000FFFF; the next frame reads 0xFFFF0000.
- Abort: 20 clocks, then ssi_c held high. frame_abort pulses TIMEOUT_CYCLES+1 cycles after the last rise detect. frame_cnt is unchanged, ssi_d=1, busy=0.
- Overclock: 50 falls. Bits after 44 read 0. A single frame_done pulse; frame_cnt increments by 1.
- Reset and wrap: rst_syn high at bit 20 gives ssi_d=1 and busy=0 immediately, and the next frame is a correct full frame. 256 frames wrap frame_cnt to 0.
